// File: rtl/scan_result_fifo.sv
// scan_result_fifo: captures {data_ex, counter_time_ex} from the pulse counter on each rising edge
// of stop into a DEPTH-entry FIFO. The host drains it over the 8-bit addr/data register bus.
// Optional feature macro: SCAN_FIFO_TIMESTAMP_EN adds a free-running 32-bit cycle counter that is
// stored with each entry and readable at BASE_ADDR+12..+15.
module scan_result_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  BASE_ADDR  = 8'h40
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  stop,
  input  logic [31:0]           data_ex,
  input  logic [31:0]           counter_time_ex,
  input  logic [7:0]            addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  not_empty,
  output logic                  full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
`ifdef SCAN_FIFO_TIMESTAMP_EN
  localparam int unsigned EntryW = 96;
`else
  localparam int unsigned EntryW = 64;
`endif

  // Entry layout: [31:0] counter_time_ex, [63:32] data_ex, [95:64] timestamp (optional)
  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e               r_state;
  logic                 r_stop_d;
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [7:0]           r_ovf_cnt;
  logic                 r_ovf_flag;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [EntryW-1:0]    r_mem [DEPTH];

  logic                 w_ctrl_hit;
  logic                 w_clear;
  logic                 w_pop;
  logic                 w_cap;
  logic                 w_push;
  logic                 w_ovf;
  logic                 w_full;
  logic                 w_empty;
  logic [EntryW-1:0]    w_entry;
  logic [EntryW-1:0]    w_head;
  logic [7:0]           w_offset;
  logic [7:0]           w_rd_data;
  logic                 w_unused_data_in;

`ifdef SCAN_FIFO_TIMESTAMP_EN
  logic [31:0]          r_ts;

  // Free-running cycle counter sampled into each captured entry
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_ts <= 32'd0;
    end else begin
      r_ts <= r_ts + 32'd1;
    end
  end

  assign w_entry = {r_ts, data_ex, counter_time_ex};
`else
  assign w_entry = {data_ex, counter_time_ex};
`endif

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Control decode; clear overrides both pop and a coincident capture
  assign w_ctrl_hit = we && (addr == BASE_ADDR + 8'd11);
  assign w_clear    = w_ctrl_hit && data_in[1];
  assign w_pop      = w_ctrl_hit && data_in[0] && !w_empty && !w_clear;
  assign w_cap      = (r_state == S_CAPTURE);
  // Fullness is judged before any same-cycle pop, so a pop never makes room for this capture
  assign w_push     = w_cap && !w_full && !w_clear;
  assign w_ovf      = w_cap && w_full && !w_clear;

  assign w_unused_data_in = ^data_in[DATA_WIDTH-1:2];

  // Capture FSM: one capture per rising edge of stop, then wait for stop to drop
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state  <= S_IDLE;
      r_stop_d <= 1'b1;  // a stop already high at reset release is not an edge
    end else begin
      r_stop_d <= stop;
      unique case (r_state)
        S_IDLE: begin
          if (stop && !r_stop_d) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!stop) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pointers, occupancy and overflow bookkeeping
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf_cnt  <= 8'd0;
      r_ovf_flag <= 1'b0;
    end else if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf_cnt  <= 8'd0;
      r_ovf_flag <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      if (w_ovf) begin
        r_ovf_flag <= 1'b1;
        if (r_ovf_cnt != 8'hFF) begin
          r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
      end
    end
  end

  // Entry storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign w_offset = addr - BASE_ADDR;

  // Register read mux; head fields read zero while the FIFO is empty
  always_comb begin
    w_rd_data = 8'h00;
    if (w_offset < 8'd16) begin
      case (w_offset[3:0])
        4'd0: w_rd_data = 8'(r_count);
        4'd1: w_rd_data = {5'b0, r_ovf_flag, w_full, w_empty};
        4'd2: w_rd_data = r_ovf_cnt;
        4'd3: w_rd_data = w_empty ? 8'h00 : w_head[39:32];
        4'd4: w_rd_data = w_empty ? 8'h00 : w_head[47:40];
        4'd5: w_rd_data = w_empty ? 8'h00 : w_head[55:48];
        4'd6: w_rd_data = w_empty ? 8'h00 : w_head[63:56];
        4'd7: w_rd_data = w_empty ? 8'h00 : w_head[7:0];
        4'd8: w_rd_data = w_empty ? 8'h00 : w_head[15:8];
        4'd9: w_rd_data = w_empty ? 8'h00 : w_head[23:16];
        4'd10: w_rd_data = w_empty ? 8'h00 : w_head[31:24];
`ifdef SCAN_FIFO_TIMESTAMP_EN
        4'd12: w_rd_data = w_empty ? 8'h00 : w_head[71:64];
        4'd13: w_rd_data = w_empty ? 8'h00 : w_head[79:72];
        4'd14: w_rd_data = w_empty ? 8'h00 : w_head[87:80];
        4'd15: w_rd_data = w_empty ? 8'h00 : w_head[95:88];
`endif
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  // Read data is registered from addr every cycle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_data_out <= '0;
    end else begin
      r_data_out <= DATA_WIDTH'(w_rd_data);
    end
  end

  assign data_out  = r_data_out;
  assign not_empty = !w_empty;
  assign full      = w_full;

endmodule
